// File: rtl/debounce_bank.sv
// Multi-channel input conditioner: two-flop synchroniser, shared prescaled
// sample strobe, and per-channel hold-count debounce with rise/fall strobes.
module debounce_bank #(
  parameter int CHANNELS = 2,
  parameter int PRESCALE = 16,
  parameter int HOLD     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] C_LAST = CW'(HOLD - 1);

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [PW-1:0]       p;
  logic [CW-1:0]       c [CHANNELS];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      p <= '0;
    else if (p == P_LAST)
      p <= '0;
    else
      p <= p + 1'b1;
  end

  // Masked during reset so a PRESCALE of 1 still shows tick low while held in reset.
  assign tick = !reset && (p == P_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      out  <= '0;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < CHANNELS; i++)
        c[i] <= '0;
    end else begin
      rise <= '0;
      fall <= '0;
      if (tick) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (s2[i] == out[i]) begin
            c[i] <= '0;
          end else if (c[i] == C_LAST) begin
            out[i]  <= s2[i];
            c[i]    <= '0;
            rise[i] <= s2[i];
            fall[i] <= ~s2[i];
          end else begin
            c[i] <= c[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule
